// File: rtl/oddr_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : oddr_tx_serializer
// Description : Feeds one ODDR primitive (SAME_EDGE, SYNC reset, CE high).
//               Takes parallel words on a valid/ready interface and drives
//               ODDR D1/D2 with two bits per C cycle. It also sequences the
//               ODDR reset: R is held high for RST_CYCLES edges after RN
//               releases.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   C        in   1      clock, shared with the ODDR C input
//   RN       in   1      asynchronous active-low reset
//   EN       in   1      1 = accept words; 0 = finish the current word, then idle
//   S_VALID  in   1      source presents a word on S_DATA
//   S_DATA   in   WIDTH  word to serialize
//   S_READY  out  1      word is taken on a rising C edge with S_VALID & S_READY
//   ODDR_R   out  1      ODDR R (active-high synchronous reset)
//   ODDR_D1  out  1      ODDR D1, sent during the C-high half
//   ODDR_D2  out  1      ODDR D2, sent during the C-low half
//   BUSY     out  1      high while a word is being sent
//   WORD_CNT out  16     accepted-word count, modulo 2^16
// Parameters
//   WIDTH (even, >= 2), RST_CYCLES (>= 1), IDLE (idle line level),
//   MSB_FIRST (0: bit 0 goes out first, 1: bit WIDTH-1 goes out first)
// ============================================================================
module oddr_tx_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   RST_CYCLES = 4,
    parameter logic IDLE       = 1'b0,
    parameter bit   MSB_FIRST  = 1'b0
) (
    input  logic             C,
    input  logic             RN,
    input  logic             EN,
    input  logic             S_VALID,
    input  logic [WIDTH-1:0] S_DATA,
    output logic             S_READY,
    output logic             ODDR_R,
    output logic             ODDR_D1,
    output logic             ODDR_D2,
    output logic             BUSY,
    output logic [15:0]      WORD_CNT
);

    localparam int c_NB = WIDTH / 2;
    localparam int c_BW = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam int c_HW = $clog2(RST_CYCLES + 1);

    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(c_NB - 1);
    localparam logic [c_BW-1:0] c_BEAT_ONE  = c_BW'(1);
    localparam logic [c_HW-1:0] c_HOLD_INIT = c_HW'(RST_CYCLES);
    localparam logic [c_HW-1:0] c_HOLD_ONE  = c_HW'(1);

    localparam logic [1:0] c_ST_RST_HOLD = 2'd0;
    localparam logic [1:0] c_ST_IDLE     = 2'd1;
    localparam logic [1:0] c_ST_SHIFT    = 2'd2;

    logic [1:0]       r_state;
    logic [c_HW-1:0]  r_hold_cnt;
    logic [c_BW-1:0]  r_beat;
    logic [WIDTH-1:0] r_shift;
    logic             r_oddr_r;
    logic             r_d1;
    logic             r_d2;
    logic             r_busy;
    logic [15:0]      r_word_cnt;

    // Pair 0 is taken straight from S_DATA at the handshake; the remainder of
    // the word is parked in r_shift with the next pair always at the output end.
    logic             w_load_d1;
    logic             w_load_d2;
    logic [WIDTH-1:0] w_load_rest;
    logic             w_shift_d1;
    logic             w_shift_d2;
    logic [WIDTH-1:0] w_shift_rest;
    logic             w_last_beat;
    logic             w_s_ready;
    logic             w_hs;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_load_d1    = S_DATA[WIDTH-1];
            assign w_load_d2    = S_DATA[WIDTH-2];
            assign w_load_rest  = S_DATA << 2;
            assign w_shift_d1   = r_shift[WIDTH-1];
            assign w_shift_d2   = r_shift[WIDTH-2];
            assign w_shift_rest = r_shift << 2;
        end else begin : g_lsb_first
            assign w_load_d1    = S_DATA[0];
            assign w_load_d2    = S_DATA[1];
            assign w_load_rest  = S_DATA >> 2;
            assign w_shift_d1   = r_shift[0];
            assign w_shift_d2   = r_shift[1];
            assign w_shift_rest = r_shift >> 2;
        end
    endgenerate

    assign w_last_beat = (r_beat == c_LAST_BEAT);

    // Ready is offered in the last beat of a word, so the next word follows
    // without an idle beat. With one beat per word it stays high while EN=1.
    assign w_s_ready = EN & ((r_state == c_ST_IDLE) |
                             ((r_state == c_ST_SHIFT) & w_last_beat));
    assign w_hs      = S_VALID & w_s_ready;

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            r_state    <= c_ST_RST_HOLD;
            r_hold_cnt <= c_HOLD_INIT;
            r_beat     <= '0;
            r_shift    <= '0;
            r_oddr_r   <= 1'b1;
            r_d1       <= IDLE;
            r_d2       <= IDLE;
            r_busy     <= 1'b0;
            r_word_cnt <= 16'd0;
        end else begin
            case (r_state)
                c_ST_RST_HOLD: begin
                    r_hold_cnt <= r_hold_cnt - c_HOLD_ONE;
                    // Counter reaching zero on this edge ends the ODDR reset.
                    if (r_hold_cnt == c_HOLD_ONE) begin
                        r_oddr_r <= 1'b0;
                        r_state  <= c_ST_IDLE;
                    end
                end
                c_ST_IDLE: begin
                    if (w_hs) begin
                        r_shift <= w_load_rest;
                        r_d1    <= w_load_d1;
                        r_d2    <= w_load_d2;
                        r_beat  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (!w_last_beat) begin
                        r_shift <= w_shift_rest;
                        r_d1    <= w_shift_d1;
                        r_d2    <= w_shift_d2;
                        r_beat  <= r_beat + c_BEAT_ONE;
                    end else if (w_hs) begin
                        r_shift <= w_load_rest;
                        r_d1    <= w_load_d1;
                        r_d2    <= w_load_d2;
                        r_beat  <= '0;
                    end else begin
                        r_d1    <= IDLE;
                        r_d2    <= IDLE;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a fresh ODDR reset.
                    r_state    <= c_ST_RST_HOLD;
                    r_hold_cnt <= c_HOLD_INIT;
                    r_oddr_r   <= 1'b1;
                    r_d1       <= IDLE;
                    r_d2       <= IDLE;
                    r_busy     <= 1'b0;
                end
            endcase

            if (w_hs) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

    assign S_READY  = w_s_ready;
    assign ODDR_R   = r_oddr_r;
    assign ODDR_D1  = r_d1;
    assign ODDR_D2  = r_d2;
    assign BUSY     = r_busy;
    assign WORD_CNT = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_oddr_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_oddr_tx_serializer
// Description : Self-checking bench for oddr_tx_serializer. Three instances
//               (8-bit LSB-first, 8-bit MSB-first with IDLE=1, 2-bit) share
//               one stimulus; a transaction-level model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oddr_tx_serializer;

    logic        r_c     = 1'b0;
    logic        r_rn    = 1'b0;
    logic        r_en    = 1'b0;
    logic        r_valid = 1'b0;
    logic [7:0]  r_data  = 8'h00;

    logic [2:0]  w_ready;
    logic [2:0]  w_oddr_r;
    logic [2:0]  w_d1;
    logic [2:0]  w_d2;
    logic [2:0]  w_busy;
    logic [15:0] w_cnt [3];

    int checks = 0;
    int errors = 0;

    // Per-instance configuration
    int   c_w   [3] = '{8, 8, 2};
    int   c_rst [3] = '{4, 3, 1};
    logic c_msb [3] = '{1'b0, 1'b1, 1'b0};
    logic c_idl [3] = '{1'b0, 1'b1, 1'b0};

    // Model: pending pairs of the current word, the pair on the wire, the
    // remaining ODDR reset edges and the word count.
    logic [1:0]  m_q     [3][4];
    int          m_qh    [3];
    int          m_qc    [3];
    logic [1:0]  m_shown [3];
    logic        m_sv    [3];
    int          m_hold  [3];
    logic [15:0] m_cnt   [3];

    always #5 r_c = ~r_c;

    oddr_tx_serializer #(.WIDTH(8), .RST_CYCLES(4), .IDLE(1'b0), .MSB_FIRST(1'b0)) u_i0 (
        .C(r_c), .RN(r_rn), .EN(r_en), .S_VALID(r_valid), .S_DATA(r_data),
        .S_READY(w_ready[0]), .ODDR_R(w_oddr_r[0]), .ODDR_D1(w_d1[0]),
        .ODDR_D2(w_d2[0]), .BUSY(w_busy[0]), .WORD_CNT(w_cnt[0]));

    oddr_tx_serializer #(.WIDTH(8), .RST_CYCLES(3), .IDLE(1'b1), .MSB_FIRST(1'b1)) u_i1 (
        .C(r_c), .RN(r_rn), .EN(r_en), .S_VALID(r_valid), .S_DATA(r_data),
        .S_READY(w_ready[1]), .ODDR_R(w_oddr_r[1]), .ODDR_D1(w_d1[1]),
        .ODDR_D2(w_d2[1]), .BUSY(w_busy[1]), .WORD_CNT(w_cnt[1]));

    oddr_tx_serializer #(.WIDTH(2), .RST_CYCLES(1), .IDLE(1'b0), .MSB_FIRST(1'b0)) u_i2 (
        .C(r_c), .RN(r_rn), .EN(r_en), .S_VALID(r_valid), .S_DATA(r_data[1:0]),
        .S_READY(w_ready[2]), .ODDR_R(w_oddr_r[2]), .ODDR_D1(w_d1[2]),
        .ODDR_D2(w_d2[2]), .BUSY(w_busy[2]), .WORD_CNT(w_cnt[2]));

    task automatic chk(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    // {D1,D2} of beat b of word wv for instance i, straight from the bit order rule
    function automatic logic [1:0] pair_of(input int i, input logic [7:0] wv, input int b);
        int w;
        w = c_w[i];
        if (c_msb[i]) return {wv[w-1-2*b], wv[w-2-2*b]};
        else          return {wv[2*b], wv[2*b+1]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_qh[i]   = 0;
            m_qc[i]   = 0;
            m_sv[i]   = 1'b0;
            m_shown[i] = 2'b00;
            m_hold[i] = c_rst[i];
            m_cnt[i]  = 16'h0000;
        end
    endtask

    task automatic check_outputs();
        logic [1:0] ep;
        for (int i = 0; i < 3; i++) begin
            ep = m_sv[i] ? m_shown[i] : {c_idl[i], c_idl[i]};
            chk("ODDR_D1", i, 16'(w_d1[i]), 16'(ep[1]));
            chk("ODDR_D2", i, 16'(w_d2[i]), 16'(ep[0]));
            chk("BUSY", i, 16'(w_busy[i]), 16'(m_sv[i]));
            chk("ODDR_R", i, 16'(w_oddr_r[i]), 16'(m_hold[i] > 0));
            chk("WORD_CNT", i, w_cnt[i], m_cnt[i]);
        end
    endtask

    task automatic edge_update(input logic [2:0] hs);
        int nb;
        if (!r_rn) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (m_hold[i] > 0) begin
                m_hold[i]--;
            end else begin
                if (hs[i]) begin
                    m_cnt[i] = m_cnt[i] + 16'd1;
                    nb = c_w[i] / 2;
                    for (int b = 0; b < nb; b++) m_q[i][b] = pair_of(i, r_data, b);
                    m_qh[i] = 0;
                    m_qc[i] = nb;
                end
                if (m_qc[i] > 0) begin
                    m_shown[i] = m_q[i][m_qh[i]];
                    m_qh[i]++;
                    m_qc[i]--;
                    m_sv[i] = 1'b1;
                end else begin
                    m_sv[i] = 1'b0;
                end
            end
        end
    endtask

    // One clock cycle: check ready before the edge, advance the model at the
    // edge, check the registered outputs just after it.
    task automatic step();
        logic [2:0] hs;
        logic       er;
        #1;
        for (int i = 0; i < 3; i++) begin
            er = r_rn && (m_hold[i] == 0) && (m_qc[i] == 0) && r_en;
            chk("S_READY", i, 16'(w_ready[i]), 16'(er));
            hs[i] = r_valid & er;
        end
        @(posedge r_c);
        #1;
        edge_update(hs);
        check_outputs();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge r_c);
        #1;
        // Reset state, then release with EN=1
        repeat (2) step();
        r_en = 1'b1;
        r_rn = 1'b1;
        repeat (5) step();

        // Single word 8'hB4
        r_data  = 8'hB4;
        r_valid = 1'b1;
        step();
        r_valid = 1'b0;
        repeat (5) step();

        // Back-to-back 8'hFF then 8'h00
        r_data  = 8'hFF;
        r_valid = 1'b1;
        step();
        r_data  = 8'h00;
        repeat (4) step();
        r_valid = 1'b0;
        repeat (5) step();

        // EN dropped during beat 1 with S_VALID held
        r_data  = 8'($urandom);
        r_valid = 1'b1;
        repeat (2) step();
        r_en = 1'b0;
        repeat (6) step();
        r_en    = 1'b1;
        r_valid = 1'b0;
        step();

        // RN pulsed low during beat 2
        r_data  = 8'($urandom);
        r_valid = 1'b1;
        step();
        r_valid = 1'b0;
        repeat (2) step();
        r_rn = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) chk("S_READY_async", i, 16'(w_ready[i]), 16'(0));
        check_outputs();
        step();
        r_rn = 1'b1;
        repeat (5) step();

        // Preload the word counters near the top and cross the wrap
        force u_i0.r_word_cnt = 16'hFFFE;
        force u_i1.r_word_cnt = 16'hFFFE;
        force u_i2.r_word_cnt = 16'hFFFE;
        #1;
        release u_i0.r_word_cnt;
        release u_i1.r_word_cnt;
        release u_i2.r_word_cnt;
        for (int i = 0; i < 3; i++) m_cnt[i] = 16'hFFFE;
        r_valid = 1'b1;
        repeat (10) begin
            r_data = 8'($urandom);
            step();
        end
        r_valid = 1'b0;
        repeat (5) step();

        // Randomized traffic
        repeat (400) begin
            r_en    = ($urandom_range(0, 7) != 0);
            r_valid = 1'($urandom_range(0, 1));
            r_data  = 8'($urandom);
            step();
        end
        r_en    = 1'b1;
        r_valid = 1'b0;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
